// File: rtl/sortmax_key_pkg.sv
// Shared types and defaults for the sortmax key loader: FSM encoding,
// registered control-output bundle and the saturating retry increment.
package sortmax_key_pkg;

  localparam int KEY_W_DEF     = 8;
  localparam int MAX_RETRY_DEF = 3;
  localparam int X_W_DEF       = 5;
  localparam int FCNT_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_ARMED = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  typedef struct packed {
    logic              key_ok;
    logic              key_err;
    logic              fsm_rst;
    logic [FCNT_W-1:0] fail_cnt;
  } ctl_t;

  localparam ctl_t CTL_RST = '{key_ok: 1'b0, key_err: 1'b0, fsm_rst: 1'b1,
                               fail_cnt: '0};

  // Retry count never wraps; it parks at the limit.
  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v,
                                                input int lim);
    return (int'(v) >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sortmax_key_shreg.sv
// Serial key capture: (KEY_W+1)-bit LSB-first shift register, bit counter,
// running parity and a flag marking the parity-bit slot.
module sortmax_key_shreg
  import sortmax_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] key,
  output logic             par,
  output logic             last
);

  localparam int CW = $clog2(KEY_W + 1);

  logic [KEY_W:0] sreg;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg <= '0;
      cnt  <= '0;
      par  <= 1'b0;
    end else if (shift_en) begin
      sreg <= {bit_in, sreg[KEY_W:1]};
      cnt  <= cnt + 1'b1;
      par  <= par ^ bit_in;
    end
  end

  assign key  = sreg[KEY_W-1:0];
  // High while the next accepted bit is the trailing parity bit.
  assign last = (cnt == CW'(KEY_W));

endmodule

// File: rtl/sortmax_key_loader.sv
// Key loader ahead of the sortmax FSM: serial key intake with even-parity
// check, retry budget, FSM reset release and registered condition inputs.
module sortmax_key_loader
  import sortmax_key_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int X_W       = X_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              kin_valid,
  input  logic              kin_bit,
  output logic              kin_ready,
  input  logic [X_W-1:0]    x_in,
  output logic [X_W-1:0]    x_out,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_ok,
  output logic              key_err,
  output logic              fsm_rst,
  output logic [FCNT_W-1:0] fail_cnt
);

  state_t            state, state_n;
  ctl_t              ctl, ctl_n;
  logic [KEY_W-1:0]  key_q, key_n;
  logic [KEY_W-1:0]  sh_key;
  logic              sh_par, sh_last;
  logic              clr, accept;
  logic [FCNT_W-1:0] fail_inc;

  assign kin_ready = (state == ST_SHIFT);
  assign accept    = kin_valid & kin_ready;

  sortmax_key_shreg #(.KEY_W(KEY_W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (accept),
    .bit_in   (kin_bit),
    .key      (sh_key),
    .par      (sh_par),
    .last     (sh_last)
  );

  always_comb begin
    state_n  = state;
    ctl_n    = ctl;
    key_n    = key_q;
    clr      = 1'b0;
    fail_inc = sat_inc(ctl.fail_cnt, MAX_RETRY);
    case (state)
      ST_IDLE: begin
        if (load_req) begin
          state_n = ST_SHIFT;
          clr     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (accept && sh_last) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (!sh_par) begin
          key_n          = sh_key;
          ctl_n.key_ok   = 1'b1;
          ctl_n.fsm_rst  = 1'b0;
          ctl_n.fail_cnt = '0;
          state_n        = ST_ARMED;
        end else begin
          ctl_n.fail_cnt = fail_inc;
          if (fail_inc == FCNT_W'(MAX_RETRY)) begin
            state_n       = ST_FAIL;
            ctl_n.key_err = 1'b1;
            ctl_n.key_ok  = 1'b0;
            ctl_n.fsm_rst = 1'b1;
            key_n         = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_ARMED: begin
        // Rekey holds the FSM in reset but keeps the old key visible.
        if (load_req) begin
          state_n       = ST_SHIFT;
          clr           = 1'b1;
          ctl_n.key_ok  = 1'b0;
          ctl_n.fsm_rst = 1'b1;
        end
      end
      ST_FAIL: begin
        ctl_n.key_err = 1'b1;
        ctl_n.key_ok  = 1'b0;
        ctl_n.fsm_rst = 1'b1;
        key_n         = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ctl   <= CTL_RST;
      key_q <= '0;
      x_out <= '0;
    end else begin
      state <= state_n;
      ctl   <= ctl_n;
      key_q <= key_n;
      // Gate on next-cycle reset so the FSM never sees x while held in reset.
      x_out <= ctl_n.fsm_rst ? '0 : x_in;
    end
  end

  assign key_out  = key_q;
  assign key_ok   = ctl.key_ok;
  assign key_err  = ctl.key_err;
  assign fsm_rst  = ctl.fsm_rst;
  assign fail_cnt = ctl.fail_cnt;

endmodule

// File: tb/tb_sortmax_key_loader.sv
// Bench for sortmax_key_loader: vector table, directed corner sequences and
// randomized loads against a transaction-level key/retry model.
module tb_sortmax_key_loader;

  localparam int KEY_W     = 8;
  localparam int MAX_RETRY = 3;
  localparam int X_W       = 5;

  logic             clk = 1'b0;
  logic             rst, load_req, kin_valid, kin_bit;
  logic             kin_ready, key_ok, key_err, fsm_rst;
  logic [X_W-1:0]   x_in, x_out;
  logic [KEY_W-1:0] key_out;
  logic [1:0]       fail_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_bits = 0;

  always #5 clk = ~clk;

  sortmax_key_loader #(.KEY_W(KEY_W), .MAX_RETRY(MAX_RETRY), .X_W(X_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .kin_valid (kin_valid),
    .kin_bit   (kin_bit),
    .kin_ready (kin_ready),
    .x_in      (x_in),
    .x_out     (x_out),
    .key_out   (key_out),
    .key_ok    (key_ok),
    .key_err   (key_err),
    .fsm_rst   (fsm_rst),
    .fail_cnt  (fail_cnt)
  );

  // Independent count of handshakes seen on the bus.
  always @(posedge clk) if (!rst && kin_valid && kin_ready) acc_bits <= acc_bits + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] key;
    logic       par;
    logic [7:0] e_key;
    logic       e_ok;
    logic [1:0] e_fail;
    logic       e_err;
  } vec_t;

  vec_t       tbl[13];
  logic [7:0] m_key;
  logic       m_ok, m_err;
  int         m_fail;
  logic [7:0] rk;
  logic       rp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; load_req = 1'b0; kin_valid = 1'b0; kin_bit = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_kin_ready", kin_ready, 0);
    chk("rst_key_out",   key_out,   0);
    chk("rst_key_ok",    key_ok,    0);
    chk("rst_key_err",   key_err,   0);
    chk("rst_fsm_rst",   fsm_rst,   1);
    chk("rst_x_out",     x_out,     0);
    chk("rst_fail_cnt",  fail_cnt,  0);
  endtask

  task automatic chk_out(input logic [7:0] ek, input logic eo, input int ef, input logic ee);
    chk("key_out",  key_out,  ek);
    chk("key_ok",   key_ok,   eo);
    chk("fail_cnt", fail_cnt, ef);
    chk("key_err",  key_err,  ee);
    chk("fsm_rst",  fsm_rst,  !eo);
    chk("ready_after_check", kin_ready, 0);
  endtask

  // Send frame bits lo..hi with 0..maxgap idle cycles of garbage before each.
  task automatic send_bits(input logic [8:0] fr, input int lo, input int hi, input int maxgap);
    int g, t;
    for (int i = lo; i <= hi; i++) begin
      g = $urandom_range(0, maxgap);
      kin_valid = 1'b0;
      repeat (g) begin kin_bit = 1'($urandom); step(); end
      kin_valid = 1'b1;
      kin_bit   = fr[i];
      t = 0;
      while (!kin_ready && t < 16) begin step(); t++; end
      chk("kin_ready_wait", kin_ready, 1);
      step();
    end
  endtask

  task automatic do_load(input logic [7:0] k, input logic p, input int maxgap, input bit hold);
    int snap;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("ready_after_load", kin_ready, 1);
    chk("ok_during_load",   key_ok,    0);
    chk("fsm_rst_on_load",  fsm_rst,   1);
    chk("x_out_on_load",    x_out,     0);
    snap = acc_bits;
    send_bits({p, k}, 0, 8, maxgap);
    chk("ready_in_check", kin_ready, 0);
    chk("ok_in_check",    key_ok,    0);
    step();
    if (hold) begin step(); step(); end
    kin_valid = 1'b0;
    chk("bits_per_load", acc_bits - snap, 9);
  endtask

  task automatic model_load(input logic [7:0] k, input logic p);
    if ((^k ^ p) == 1'b0) begin
      m_key = k; m_ok = 1'b1; m_fail = 0;
    end else begin
      m_ok = 1'b0;
      if (m_fail < MAX_RETRY) m_fail++;
      if (m_fail == MAX_RETRY) begin m_err = 1'b1; m_key = '0; end
    end
  endtask

  initial begin
    tbl[0]  = '{8'hA5, 1'b0, 8'hA5, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{8'h3C, 1'b0, 8'h3C, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{8'h01, 1'b0, 8'h3C, 1'b0, 2'd1, 1'b0};
    tbl[3]  = '{8'h01, 1'b1, 8'h01, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{8'hFF, 1'b1, 8'h01, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{8'h80, 1'b0, 8'h01, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{8'h80, 1'b1, 8'h80, 1'b1, 2'd0, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, 8'h80, 1'b0, 2'd1, 1'b0};
    tbl[8]  = '{8'h7F, 1'b0, 8'h80, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{8'h00, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{8'hA5, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0};
    tbl[11] = '{8'h3C, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0};
    tbl[12] = '{8'h55, 1'b1, 8'h00, 1'b0, 2'd3, 1'b1};

    x_in = 5'h1F;
    do_reset();
    chk_reset();

    // Table: chained loads, ending in retry exhaustion.
    for (int i = 0; i < 13; i++) begin
      do_load(tbl[i].key, tbl[i].par, i % 4, (i % 3) == 0);
      chk_out(tbl[i].e_key, tbl[i].e_ok, tbl[i].e_fail, tbl[i].e_err);
    end
    load_req = 1'b1; step(); load_req = 1'b0;
    kin_valid = 1'b1; step();
    chk("fail_ignores_load", kin_ready, 0);
    step();
    chk("fail_ready_stuck", kin_ready, 0);
    chk("fail_err_sticky",  key_err,   1);
    chk("fail_cnt_sat",     fail_cnt,  3);
    chk("fail_x_out",       x_out,     0);
    kin_valid = 1'b0;
    do_reset();
    chk_reset();

    // Single bad load from reset.
    do_load(8'hA5, 1'b1, 1, 1'b0);
    chk_out(8'h00, 1'b0, 1, 1'b0);
    chk("x_out_idle", x_out, 0);

    // Reset in the middle of a shift after a failure left fail_cnt set.
    do_reset();
    do_load(8'hA5, 1'b0, 0, 1'b0);
    chk_out(8'hA5, 1'b1, 0, 1'b0);
    do_load(8'hA5, 1'b1, 2, 1'b0);
    chk_out(8'hA5, 1'b0, 1, 1'b0);
    load_req = 1'b1; step(); load_req = 1'b0;
    send_bits({1'b0, 8'hA5}, 0, 3, 2);
    kin_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset();
    do_load(8'h3C, 1'b0, 3, 1'b1);
    chk_out(8'h3C, 1'b1, 0, 1'b0);

    // Armed: x passthrough, then rekey keeps the old key until the new one passes.
    do_reset();
    do_load(8'hA5, 1'b0, 1, 1'b0);
    x_in = 5'b10110;
    step();
    chk("x_out_armed", x_out, 5'b10110);
    load_req = 1'b1; step(); load_req = 1'b0;
    chk("rekey_fsm_rst", fsm_rst, 1);
    chk("rekey_key_ok",  key_ok,  0);
    chk("rekey_x_out",   x_out,   0);
    chk("rekey_key_old", key_out, 8'hA5);
    send_bits({1'b1, 8'h01}, 0, 4, 1);
    chk("midshift_key_old", key_out, 8'hA5);
    send_bits({1'b1, 8'h01}, 5, 8, 1);
    kin_valid = 1'b0;
    chk("check_key_old", key_out, 8'hA5);
    step();
    chk_out(8'h01, 1'b1, 0, 1'b0);

    // Randomized loads against the transaction model.
    do_reset();
    m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_fail = 0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_reset();
        m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_fail = 0;
        chk_out(m_key, m_ok, m_fail, m_err);
      end
      if (m_err) begin
        load_req = 1'b1; step(); load_req = 1'b0; step();
        chk("rnd_fail_ready", kin_ready, 0);
        chk("rnd_fail_err",   key_err,   1);
        do_reset();
        m_key = '0; m_ok = 1'b0; m_err = 1'b0; m_fail = 0;
        continue;
      end
      rk = 8'($urandom);
      rp = (^rk) ^ ($urandom_range(0, 4) < 2);
      x_in = 5'($urandom);
      do_load(rk, rp, 3, 1'($urandom));
      model_load(rk, rp);
      chk_out(m_key, m_ok, m_fail, m_err);
      x_in = 5'($urandom);
      step();
      chk("rnd_x_out", x_out, m_ok ? x_in : 5'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
